sha256_padder: RTL

- Upstream feeder for the SHA-256 core wrapper.
- Accepts a byte-granular 32-bit word stream and assembles 512-bit message blocks.
- Appends FIPS 180-4 padding: the 0x80 byte, zero fill, and the 64-bit big-endian bit length.
- Sequences the core's init/next/ready handshake, so software or DMA need not pad or pace blocks.

---
 rtl/sha256_pkg.sv | 19 +
 rtl/sha256_pad_fmt.sv | 25 ++
 rtl/sha256_padder.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// Shared constants and FSM state type for the SHA-256 message padder.
// Imported by sha256_padder and sha256_pad_fmt.
package sha256_pkg;

  localparam int SHA256_BLK_W   = 512;
  localparam int SHA256_WORDS   = 16;
  localparam int SHA256_LEN_OFF = 448;

  localparam logic [7:0] PAD_BYTE = 8'h80;

  typedef enum logic [2:0] {
    ST_FILL,
    ST_PAD,
    ST_EXTRA,
    ST_ISSUE,
    ST_WAIT
  } state_t;

endpackage

// File: rtl/sha256_pad_fmt.sv
// Masks unused bytes of a final message word and inserts the 0x80 marker.
// Bytes are MSB-aligned; byte 0 sits in [31:24].
module sha256_pad_fmt
  import sha256_pkg::*;
(
  input  logic [31:0] data,
  input  logic [2:0]  bytes,
  input  logic        pad,
  output logic [31:0] word
);

  always_comb begin
    word = data;
    if (pad) begin
      for (int k = 0; k < 4; k++) begin
        if (3'(k) == bytes) begin
          word[31-8*k -: 8] = PAD_BYTE;
        end else if (3'(k) > bytes) begin
          word[31-8*k -: 8] = 8'h00;
        end
      end
    end
  end

endmodule

// File: rtl/sha256_padder.sv
// SHA-256 block assembler/padder driving the core init/next/ready handshake.
// Define SHA256_PAD_BLKCNT_EN to add the blk_cnt_o issued-block counter.
module sha256_padder
  import sha256_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_ni,
  input  logic [31:0]             s_data_i,
  input  logic                    s_valid_i,
  input  logic                    s_last_i,
  input  logic [2:0]              s_bytes_i,
  output logic                    s_ready_o,
  output logic [SHA256_BLK_W-1:0] block_o,
  output logic                    init_o,
  output logic                    next_o,
  input  logic                    core_ready_i,
  output logic                    busy_o,
  output logic                    msg_done_o
`ifdef SHA256_PAD_BLKCNT_EN
  ,
  output logic [31:0]             blk_cnt_o
`endif
);

  localparam int LEN_LSB = SHA256_BLK_W - 1 - SHA256_LEN_OFF;

  state_t                  state;
  logic [3:0]              idx;
  logic [3:0]              pad_idx;
  logic [2:0]              lb;
  logic                    first;
  logic                    final_blk;
  logic                    extra;
  logic                    pad_first;
  logic [LEN_W-1:0]        len;
  logic [63:0]             len64;
  logic [63:0]             len_sum;
  logic [31:0]             fmt_word;
  logic [2:0]              add_bytes;
  logic [6:0]              b;
  logic [SHA256_BLK_W-1:0] pad_blk;
  logic [SHA256_BLK_W-1:0] extra_blk;
  logic                    accept;

  assign accept    = s_valid_i & s_ready_o;
  assign add_bytes = s_last_i ? s_bytes_i : 3'd4;
  assign len64     = 64'(len);
  assign len_sum   = len64 + {58'd0, add_bytes, 3'd0};
  assign b         = {1'b0, pad_idx, 2'b00} + {4'd0, lb};

  sha256_pad_fmt u_fmt (
    .data  (s_data_i),
    .bytes (add_bytes),
    .pad   (s_last_i),
    .word  (fmt_word)
  );

  // A full final word leaves the 0x80 marker for the following word slot.
  always_comb begin
    pad_blk = block_o;
    for (int j = 0; j < SHA256_WORDS; j++) begin
      if (j > int'(pad_idx)) begin
        if (j == int'(pad_idx) + 1 && lb == 3'd4) begin
          pad_blk[SHA256_BLK_W-1-32*j -: 32] = {PAD_BYTE, 24'd0};
        end else begin
          pad_blk[SHA256_BLK_W-1-32*j -: 32] = 32'd0;
        end
      end
    end
    if (b <= 7'd55) begin
      pad_blk[LEN_LSB -: 64] = len64;
    end
  end

  always_comb begin
    extra_blk = '0;
    if (pad_first) begin
      extra_blk[SHA256_BLK_W-1 -: 8] = PAD_BYTE;
    end
    extra_blk[LEN_LSB -: 64] = len64;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state      <= ST_FILL;
      s_ready_o  <= 1'b0;
      block_o    <= '0;
      init_o     <= 1'b0;
      next_o     <= 1'b0;
      msg_done_o <= 1'b0;
      busy_o     <= 1'b0;
      len        <= '0;
      idx        <= '0;
      pad_idx    <= '0;
      lb         <= '0;
      first      <= 1'b1;
      final_blk  <= 1'b0;
      extra      <= 1'b0;
      pad_first  <= 1'b0;
    end else begin
      init_o     <= 1'b0;
      next_o     <= 1'b0;
      msg_done_o <= 1'b0;
      unique case (state)
        ST_FILL: begin
          s_ready_o <= 1'b1;
          if (accept) begin
            block_o[(SHA256_WORDS-1-int'(idx))*32 +: 32] <= fmt_word;
            idx    <= idx + 4'd1;
            len    <= len_sum[LEN_W-1:0];
            busy_o <= 1'b1;
            if (s_last_i) begin
              s_ready_o <= 1'b0;
              pad_idx   <= idx;
              lb        <= add_bytes;
              state     <= ST_PAD;
            end else if (idx == 4'd15) begin
              s_ready_o <= 1'b0;
              state     <= ST_ISSUE;
            end
          end
        end
        ST_PAD: begin
          block_o   <= pad_blk;
          final_blk <= (b <= 7'd55);
          extra     <= (b > 7'd55);
          pad_first <= (b == 7'd64);
          state     <= ST_ISSUE;
        end
        ST_EXTRA: begin
          block_o   <= extra_blk;
          final_blk <= 1'b1;
          extra     <= 1'b0;
          state     <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (core_ready_i) begin
            init_o <= first;
            next_o <= !first;
            first  <= 1'b0;
            state  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // The core has not yet seen the pulse, so its ready is stale here.
          if (core_ready_i && !(init_o || next_o)) begin
            if (final_blk) begin
              msg_done_o <= 1'b1;
              busy_o     <= 1'b0;
              len        <= '0;
              idx        <= '0;
              first      <= 1'b1;
              final_blk  <= 1'b0;
              s_ready_o  <= 1'b1;
              state      <= ST_FILL;
            end else if (extra) begin
              state <= ST_EXTRA;
            end else begin
              idx       <= '0;
              s_ready_o <= 1'b1;
              state     <= ST_FILL;
            end
          end
        end
        default: state <= ST_FILL;
      endcase
    end
  end

`ifdef SHA256_PAD_BLKCNT_EN
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      blk_cnt_o <= '0;
    end else if (init_o || next_o) begin
      blk_cnt_o <= blk_cnt_o + 32'd1;
    end
  end
`endif

endmodule
